// File: rtl/four_bit_seq_divider.sv
// Sequential restoring divider: Q = A / B, R = A % B, one quotient bit per clock.
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds port signed_op).
module four_bit_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Two's complement magnitude when en is set and the value is negative.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic en);
        logic [WIDTH-1:0] res;
        if (en && v[WIDTH-1]) begin
            res = -v;
        end else begin
            res = v;
        end
        return res;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] r_r;
    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic             zero_r;
    logic             sgn_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic             sgn_s;
    logic [WIDTH:0]   shift_rem_s;
    logic [WIDTH-1:0] shift_quo_s;
    logic [WIDTH-1:0] trial_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;

`ifdef DIV_SIGNED_EN
    assign sgn_s = signed_op;
`else
    assign sgn_s = 1'b0;
`endif

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits.
    always_comb begin
        shift_rem_s = {rem_r, quo_r[WIDTH-1]};
        shift_quo_s = {quo_r[WIDTH-2:0], 1'b0};
        trial_s     = shift_rem_s[WIDTH-1:0] - div_r;
        rem_nx_s    = shift_rem_s[WIDTH-1:0];
        quo_nx_s    = shift_quo_s;
        if (shift_rem_s >= {1'b0, div_r}) begin
            rem_nx_s = trial_s;
            quo_nx_s = {shift_quo_s[WIDTH-1:1], 1'b1};
        end else begin
            rem_nx_s = shift_rem_s[WIDTH-1:0];
            quo_nx_s = shift_quo_s;
        end
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            div_r      <= {WIDTH{1'b0}};
            q_r        <= {WIDTH{1'b0}};
            r_r        <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            zero_r     <= 1'b0;
            sgn_r      <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r     <= 1'b1;
                        rem_r      <= {WIDTH{1'b0}};
                        quo_r      <= mag(A, sgn_s);
                        div_r      <= mag(B, sgn_s);
                        cnt_r      <= {CW{1'b0}};
                        sgn_r      <= sgn_s;
                        neg_q_r    <= sgn_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r_r    <= sgn_s & A[WIDTH-1];
                        state_r    <= ST_CALC;
                        // Divide-by-zero results are final now; CALC spends one cycle before DONE.
                        if (B == {WIDTH{1'b0}}) begin
                            zero_r     <= 1'b1;
                            q_r        <= {WIDTH{1'b1}};
                            r_r        <= A;
                            div_zero_r <= 1'b1;
                        end else begin
                            zero_r     <= 1'b0;
                            div_zero_r <= 1'b0;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (zero_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        rem_r <= rem_nx_s;
                        quo_r <= quo_nx_s;
                        cnt_r <= cnt_r + CW'(1);
                        if (cnt_r == CW'(WIDTH - 1)) begin
                            if (sgn_r) begin
                                state_r <= ST_FIX;
                            end else begin
                                q_r     <= quo_nx_s;
                                r_r     <= rem_nx_s;
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                end
                ST_FIX: begin
                    // Truncation toward zero: quotient sign from XOR, remainder follows A.
                    q_r     <= neg_q_r ? -quo_r : quo_r;
                    r_r     <= neg_r_r ? -rem_r : rem_r;
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q        = q_r;
    assign R        = r_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = div_zero_r;

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Directed-vector self-checking bench for four_bit_seq_divider (WIDTH=4).
module tb_four_bit_seq_divider;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Q;
    logic [3:0] R;
    logic       busy;
    logic       done;
    logic       div_zero;
`ifdef DIV_SIGNED_EN
    logic       signed_op;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    four_bit_seq_divider #(.WIDTH(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
`ifdef DIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .A        (A),
        .B        (B),
        .Q        (Q),
        .R        (R),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for done, check latency, results and the pulse width.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic edz,
                          input int elat);
        int e;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0;
        while (!done && e < 20) begin
            @(negedge clk);
            e++;
        end
        check({tag, " latency"}, e, elat);
        check({tag, " Q"}, Q, eq);
        check({tag, " R"}, R, er);
        check({tag, " div_zero"}, div_zero, edz);
        check({tag, " busy"}, busy, 1'b1);
        @(negedge clk);
        check({tag, " done pulse"}, done, 1'b0);
        check({tag, " busy clr"}, busy, 1'b0);
        check({tag, " Q hold"}, Q, eq);
    endtask

`ifdef DIV_SIGNED_EN
    task automatic set_signed(input logic s);
        signed_op = s;
    endtask
`endif

    initial begin
        int ndone;
        int lat;
        logic [3:0] qs;
        logic [3:0] rs;
        reset_n = 1'b0; start = 1'b0; A = 4'd0; B = 4'd0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst Q", Q, 4'h0);
        check("rst R", R, 4'h0);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst dz", div_zero, 1'b0);
        reset_n = 1'b1;

        run_op("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4);
        run_op("7/0", 4'd7, 4'd0, 4'hF, 4'd7, 1'b1, 1);
        run_op("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4);
        run_op("3/5", 4'd3, 4'd5, 4'd0, 4'd3, 1'b0, 4);
        run_op("0/9", 4'd0, 4'd9, 4'd0, 4'd0, 1'b0, 4);
        run_op("15/15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 4);
        run_op("0/0", 4'd0, 4'd0, 4'hF, 4'd0, 1'b1, 1);

        // Start during CALC must be ignored and operand changes must not matter.
        @(negedge clk);
        A = 4'd9; B = 4'd2; start = 1'b1;
        @(posedge clk);
        ndone = 0; lat = -1; qs = 4'd0; rs = 4'd0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start = 1'b0;
            end else if (i == 1) begin
                start = 1'b1; A = 4'd1; B = 4'd1;
            end else if (i == 2) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                lat = i;
                qs = Q;
                rs = R;
            end
        end
        check("ign done count", ndone, 1);
        check("ign latency", lat, 4);
        check("ign Q", qs, 4'd4);
        check("ign R", rs, 4'd1);

        // Async reset mid-operation clears outputs and abandons the operation.
        @(negedge clk);
        A = 4'd14; B = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("arst busy", busy, 1'b0);
        check("arst done", done, 1'b0);
        check("arst Q", Q, 4'h0);
        check("arst R", R, 4'h0);
        @(negedge clk);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst no done", ndone, 0);
        check("arst idle busy", busy, 1'b0);

`ifdef DIV_SIGNED_EN
        set_signed(1'b1);
        run_op("s -7/2", 4'h9, 4'd2, 4'hD, 4'hF, 1'b0, 5);
        run_op("s -8/-1", 4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 5);
        run_op("s -7/0", 4'h9, 4'h0, 4'hF, 4'h9, 1'b1, 1);
        set_signed(1'b0);
        run_op("u 9/2", 4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 4);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
